// File: rtl/id_ex_stage.sv
// ----------------------------------------------------------------------------
// Module  : id_ex_stage
// Purpose : Decode->execute pipeline register of the pipelined RISC-V core.
//           Holds a single instruction behind a valid/ready handshake, forwards
//           operands from the MEM and WB stages, stalls on a load-use hazard,
//           drops its contents on a branch-redirect flush and drives one-hot
//           ALU enables plus the two ALU operands.
//
// Ports
//   clk, rst_n                 clock, asynchronous active-low reset
//   flush                      discard held and incoming instruction
//   id_valid / id_ready        decode-side handshake
//   id_alu_op                  0 add, 1 sub, 2 xor, 3 or, 4 and, 5-7 illegal
//   id_rs1, id_rs2             source register indices
//   id_rs1_data, id_rs2_data   register-file read data
//   id_imm, id_use_imm         sign-extended immediate, select imm for arg2
//   id_rd, id_reg_write        destination index and write enable
//   mem_reg_write, mem_rd      MEM stage destination
//   mem_data_ok, mem_result    MEM result and whether it is final yet
//   wb_reg_write, wb_rd        WB stage destination
//   wb_result                  WB write data
//   ex_valid / ex_ready        execute-side handshake
//   add_en .. and_en           one-hot ALU enables
//   arg1, arg2                 forwarded ALU operands
//   ex_rd, ex_reg_write        held destination and write enable
// ----------------------------------------------------------------------------
module id_ex_stage #(
    parameter int XLEN = 32
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            flush,

    input  logic            id_valid,
    output logic            id_ready,
    input  logic [2:0]      id_alu_op,
    input  logic [4:0]      id_rs1,
    input  logic [4:0]      id_rs2,
    input  logic [XLEN-1:0] id_rs1_data,
    input  logic [XLEN-1:0] id_rs2_data,
    input  logic [XLEN-1:0] id_imm,
    input  logic            id_use_imm,
    input  logic [4:0]      id_rd,
    input  logic            id_reg_write,

    input  logic            mem_reg_write,
    input  logic [4:0]      mem_rd,
    input  logic            mem_data_ok,
    input  logic [XLEN-1:0] mem_result,

    input  logic            wb_reg_write,
    input  logic [4:0]      wb_rd,
    input  logic [XLEN-1:0] wb_result,

    output logic            ex_valid,
    input  logic            ex_ready,
    output logic            add_en,
    output logic            sub_en,
    output logic            xor_en,
    output logic            or_en,
    output logic            and_en,
    output logic [XLEN-1:0] arg1,
    output logic [XLEN-1:0] arg2,
    output logic [4:0]      ex_rd,
    output logic            ex_reg_write
);

    // ALU operation encoding as delivered by decode; 5-7 are illegal.
    typedef enum logic [2:0] {
        ALU_ADD = 3'd0,
        ALU_SUB = 3'd1,
        ALU_XOR = 3'd2,
        ALU_OR  = 3'd3,
        ALU_AND = 3'd4
    } aluOp_e;

    // Held instruction state.
    logic            full_q,     full_d;
    logic [2:0]      op_q,       op_d;
    logic [4:0]      rs1_q,      rs1_d;
    logic [4:0]      rs2_q,      rs2_d;
    logic [XLEN-1:0] rs1Data_q,  rs1Data_d;
    logic [XLEN-1:0] rs2Data_q,  rs2Data_d;
    logic [XLEN-1:0] imm_q,      imm_d;
    logic            useImm_q,   useImm_d;
    logic [4:0]      rd_q,       rd_d;
    logic            regWrite_q, regWrite_d;

    // Forwarding / hazard / handshake nets.
    logic            rs1MemHit;
    logic            rs2MemHit;
    logic            rs1WbHit;
    logic            rs2WbHit;
    logic [XLEN-1:0] rs1Fwd;
    logic [XLEN-1:0] rs2Fwd;
    logic            hazard;
    logic            exValid;
    logic            fire;
    logic            accept;

    // Register-match detection against the later stages. x0 is hardwired to
    // zero, so a write "to x0" downstream must never be seen as a match.
    assign rs1MemHit = mem_reg_write && (mem_rd == rs1_q) && (rs1_q != 5'd0);
    assign rs2MemHit = mem_reg_write && (mem_rd == rs2_q) && (rs2_q != 5'd0);
    assign rs1WbHit  = wb_reg_write  && (wb_rd  == rs1_q) && (rs1_q != 5'd0);
    assign rs2WbHit  = wb_reg_write  && (wb_rd  == rs2_q) && (rs2_q != 5'd0);

    // Operand 1 forwarding: MEM is the younger producer, so it wins over WB.
    always_comb begin
        rs1Fwd = rs1Data_q;
        if (rs1_q == 5'd0) begin
            rs1Fwd = '0;
        end else if (rs1MemHit) begin
            rs1Fwd = mem_result;
        end else if (rs1WbHit) begin
            rs1Fwd = wb_result;
        end
    end

    // Operand 2 forwarding, same priority scheme as operand 1.
    always_comb begin
        rs2Fwd = rs2Data_q;
        if (rs2_q == 5'd0) begin
            rs2Fwd = '0;
        end else if (rs2MemHit) begin
            rs2Fwd = mem_result;
        end else if (rs2WbHit) begin
            rs2Fwd = wb_result;
        end
    end

    // Load-use: the MEM producer has not delivered its data yet. An rs2 match
    // is irrelevant when the instruction takes its second operand from imm.
    assign hazard = full_q && (rs1MemHit || (rs2MemHit && !useImm_q)) && !mem_data_ok;

    assign exValid  = full_q && !hazard;
    assign fire     = exValid && ex_ready;
    // A flush empties the stage at the next edge, so decode may present freely.
    assign id_ready = !full_q || fire || flush;
    assign accept   = id_valid && id_ready && !flush;

    // Next-state: flush beats capture beats drain. While an entry stays put,
    // pick up any WB write to its sources so the value survives once WB has
    // moved on and is no longer visible through forwarding.
    always_comb begin
        full_d     = full_q;
        op_d       = op_q;
        rs1_d      = rs1_q;
        rs2_d      = rs2_q;
        rs1Data_d  = rs1Data_q;
        rs2Data_d  = rs2Data_q;
        imm_d      = imm_q;
        useImm_d   = useImm_q;
        rd_d       = rd_q;
        regWrite_d = regWrite_q;

        if (flush) begin
            full_d = 1'b0;
        end else if (accept) begin
            full_d     = 1'b1;
            op_d       = id_alu_op;
            rs1_d      = id_rs1;
            rs2_d      = id_rs2;
            rs1Data_d  = id_rs1_data;
            rs2Data_d  = id_rs2_data;
            imm_d      = id_imm;
            useImm_d   = id_use_imm;
            rd_d       = id_rd;
            regWrite_d = id_reg_write;
        end else begin
            if (fire) begin
                full_d = 1'b0;
            end
            if (full_q && rs1WbHit) begin
                rs1Data_d = wb_result;
            end
            if (full_q && rs2WbHit) begin
                rs2Data_d = wb_result;
            end
        end
    end

    // State registers; reset drops the entry immediately.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            full_q     <= 1'b0;
            op_q       <= 3'd0;
            rs1_q      <= 5'd0;
            rs2_q      <= 5'd0;
            rs1Data_q  <= '0;
            rs2Data_q  <= '0;
            imm_q      <= '0;
            useImm_q   <= 1'b0;
            rd_q       <= 5'd0;
            regWrite_q <= 1'b0;
        end else begin
            full_q     <= full_d;
            op_q       <= op_d;
            rs1_q      <= rs1_d;
            rs2_q      <= rs2_d;
            rs1Data_q  <= rs1Data_d;
            rs2Data_q  <= rs2Data_d;
            imm_q      <= imm_d;
            useImm_q   <= useImm_d;
            rd_q       <= rd_d;
            regWrite_q <= regWrite_d;
        end
    end

    // One-hot enable decode. Nothing is enabled for an illegal op or when the
    // entry is not presentable, which makes the ALU produce 0.
    always_comb begin
        add_en = 1'b0;
        sub_en = 1'b0;
        xor_en = 1'b0;
        or_en  = 1'b0;
        and_en = 1'b0;
        if (exValid) begin
            case (op_q)
                ALU_ADD: add_en = 1'b1;
                ALU_SUB: sub_en = 1'b1;
                ALU_XOR: xor_en = 1'b1;
                ALU_OR:  or_en  = 1'b1;
                ALU_AND: and_en = 1'b1;
                default: ;
            endcase
        end
    end

    assign ex_valid     = exValid;
    assign arg1         = full_q ? rs1Fwd : '0;
    assign arg2         = full_q ? (useImm_q ? imm_q : rs2Fwd) : '0;
    assign ex_rd        = rd_q;
    assign ex_reg_write = full_q && regWrite_q;

endmodule

// File: tb/tb_id_ex_stage.sv
// ----------------------------------------------------------------------------
// Testbench for id_ex_stage. Directed steps drive decode and downstream
// stage inputs; each step pushes the output vector it expects onto a queue
// and the check pops it once the DUT output is due.
// ----------------------------------------------------------------------------
module tb_id_ex_stage;

    localparam logic [4:0] EN_NONE = 5'b00000;
    localparam logic [4:0] EN_ADD  = 5'b00001;
    localparam logic [4:0] EN_SUB  = 5'b00010;
    localparam logic [4:0] EN_XOR  = 5'b00100;
    localparam logic [4:0] EN_OR   = 5'b01000;
    localparam logic [4:0] EN_AND  = 5'b10000;

    logic        clk;
    logic        rst_n;
    logic        flush;
    logic        id_valid;
    logic        id_ready;
    logic [2:0]  id_alu_op;
    logic [4:0]  id_rs1;
    logic [4:0]  id_rs2;
    logic [31:0] id_rs1_data;
    logic [31:0] id_rs2_data;
    logic [31:0] id_imm;
    logic        id_use_imm;
    logic [4:0]  id_rd;
    logic        id_reg_write;
    logic        mem_reg_write;
    logic [4:0]  mem_rd;
    logic        mem_data_ok;
    logic [31:0] mem_result;
    logic        wb_reg_write;
    logic [4:0]  wb_rd;
    logic [31:0] wb_result;
    logic        ex_valid;
    logic        ex_ready;
    logic        add_en;
    logic        sub_en;
    logic        xor_en;
    logic        or_en;
    logic        and_en;
    logic [31:0] arg1;
    logic [31:0] arg2;
    logic [4:0]  ex_rd;
    logic        ex_reg_write;

    int vectors;
    int miscompares;

    // Scoreboard: expected output vectors and their tags, in order.
    logic [76:0] expQ[$];
    string       tagQ[$];

    logic [76:0] observed;
    assign observed = {ex_valid, id_ready, and_en, or_en, xor_en, sub_en, add_en,
                       arg1, arg2, ex_rd, ex_reg_write};

    id_ex_stage #(.XLEN(32)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .flush        (flush),
        .id_valid     (id_valid),
        .id_ready     (id_ready),
        .id_alu_op    (id_alu_op),
        .id_rs1       (id_rs1),
        .id_rs2       (id_rs2),
        .id_rs1_data  (id_rs1_data),
        .id_rs2_data  (id_rs2_data),
        .id_imm       (id_imm),
        .id_use_imm   (id_use_imm),
        .id_rd        (id_rd),
        .id_reg_write (id_reg_write),
        .mem_reg_write(mem_reg_write),
        .mem_rd       (mem_rd),
        .mem_data_ok  (mem_data_ok),
        .mem_result   (mem_result),
        .wb_reg_write (wb_reg_write),
        .wb_rd        (wb_rd),
        .wb_result    (wb_result),
        .ex_valid     (ex_valid),
        .ex_ready     (ex_ready),
        .add_en       (add_en),
        .sub_en       (sub_en),
        .xor_en       (xor_en),
        .or_en        (or_en),
        .and_en       (and_en),
        .arg1         (arg1),
        .arg2         (arg2),
        .ex_rd        (ex_rd),
        .ex_reg_write (ex_reg_write)
    );

    // 10 time-unit clock, rising edges at 5, 15, 25, ...
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Present one decode-side instruction.
    task automatic applyStimulus(input logic valid, input logic [2:0] op,
                                 input logic [4:0] rs1, input logic [4:0] rs2,
                                 input logic [31:0] d1, input logic [31:0] d2,
                                 input logic [31:0] imm, input logic useImm,
                                 input logic [4:0] rd, input logic rw);
        id_valid     = valid;
        id_alu_op    = op;
        id_rs1       = rs1;
        id_rs2       = rs2;
        id_rs1_data  = d1;
        id_rs2_data  = d2;
        id_imm       = imm;
        id_use_imm   = useImm;
        id_rd        = rd;
        id_reg_write = rw;
    endtask

    // Drive the MEM stage bypass inputs.
    task automatic setMem(input logic we, input logic [4:0] rd,
                          input logic [31:0] res, input logic ok);
        mem_reg_write = we;
        mem_rd        = rd;
        mem_result    = res;
        mem_data_ok   = ok;
    endtask

    // Drive the WB stage bypass inputs.
    task automatic setWb(input logic we, input logic [4:0] rd, input logic [31:0] res);
        wb_reg_write = we;
        wb_rd        = rd;
        wb_result    = res;
    endtask

    // Push the expected output vector for the next check.
    task automatic expectOut(input string tag, input logic v, input logic r,
                             input logic [4:0] en, input logic [31:0] a1,
                             input logic [31:0] a2, input logic [4:0] rd,
                             input logic rw);
        expQ.push_back({v, r, en, a1, a2, rd, rw});
        tagQ.push_back(tag);
    endtask

    // Pop the oldest expectation and compare it with the DUT outputs.
    task automatic checkOutput();
        logic [76:0] expected;
        string       tag;
        vectors++;
        if (expQ.size() == 0) begin
            miscompares++;
            $error("[TB] FAIL scoreboard_empty: observed=%h expected=<none>", observed);
        end else begin
            expected = expQ.pop_front();
            tag      = tagQ.pop_front();
            assert (observed === expected) else begin
                miscompares++;
                $error("[TB] FAIL %s: observed=%h expected=%h", tag, observed, expected);
            end
        end
    endtask

    // Advance to just after the next rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        vectors     = 0;
        miscompares = 0;
        rst_n       = 1'b0;
        flush       = 1'b0;
        ex_ready    = 1'b1;
        applyStimulus(1'b0, 3'd0, 5'd0, 5'd0, 32'h0, 32'h0, 32'h0, 1'b0, 5'd0, 1'b0);
        setMem(1'b0, 5'd0, 32'h0, 1'b0);
        setWb(1'b0, 5'd0, 32'h0);

        // Reset state.
        expectOut("reset", 1'b0, 1'b1, EN_NONE, 32'h0, 32'h0, 5'd0, 1'b0);
        #2;
        checkOutput();
        @(negedge clk);
        rst_n = 1'b1;

        // 1. Plain add goes through with one cycle of latency.
        applyStimulus(1'b1, 3'd0, 5'd1, 5'd2, 32'd5, 32'd7, 32'h0, 1'b0, 5'd5, 1'b1);
        expectOut("pipe_add", 1'b1, 1'b1, EN_ADD, 32'd5, 32'd7, 5'd5, 1'b1);
        tick();
        checkOutput();

        // 2. Back-to-back sub with immediate, then MEM/WB forwarding on rs1.
        applyStimulus(1'b1, 3'd1, 5'd3, 5'd0, 32'h33, 32'h0, 32'h10, 1'b1, 5'd6, 1'b1);
        expectOut("b2b_sub_imm", 1'b1, 1'b1, EN_SUB, 32'h33, 32'h10, 5'd6, 1'b1);
        tick();
        checkOutput();
        id_valid = 1'b0;
        ex_ready = 1'b0;
        setMem(1'b1, 5'd3, 32'hDEAD, 1'b1);
        expectOut("mem_fwd", 1'b1, 1'b0, EN_SUB, 32'hDEAD, 32'h10, 5'd6, 1'b1);
        #1;
        checkOutput();
        setWb(1'b1, 5'd3, 32'hBEEF);
        expectOut("mem_over_wb", 1'b1, 1'b0, EN_SUB, 32'hDEAD, 32'h10, 5'd6, 1'b1);
        #1;
        checkOutput();
        setMem(1'b0, 5'd0, 32'h0, 1'b0);
        expectOut("wb_fwd", 1'b1, 1'b0, EN_SUB, 32'hBEEF, 32'h10, 5'd6, 1'b1);
        #1;
        checkOutput();
        setWb(1'b0, 5'd0, 32'h0);
        expectOut("no_fwd", 1'b1, 1'b0, EN_SUB, 32'h33, 32'h10, 5'd6, 1'b1);
        #1;
        checkOutput();
        ex_ready = 1'b1;
        expectOut("drain_sub", 1'b0, 1'b1, EN_NONE, 32'h0, 32'h0, 5'd6, 1'b0);
        tick();
        checkOutput();

        // 3. Load-use on rs2: stall until MEM data is final.
        applyStimulus(1'b1, 3'd0, 5'd1, 5'd4, 32'd1, 32'd2, 32'h0, 1'b0, 5'd7, 1'b1);
        setMem(1'b1, 5'd4, 32'h44, 1'b0);
        expectOut("load_use_stall", 1'b0, 1'b0, EN_NONE, 32'd1, 32'h44, 5'd7, 1'b1);
        tick();
        checkOutput();
        id_valid = 1'b0;
        setMem(1'b1, 5'd4, 32'h4444, 1'b1);
        expectOut("load_use_release", 1'b1, 1'b1, EN_ADD, 32'd1, 32'h4444, 5'd7, 1'b1);
        #1;
        checkOutput();
        setMem(1'b0, 5'd0, 32'h0, 1'b0);
        expectOut("drain_load", 1'b0, 1'b1, EN_NONE, 32'h0, 32'h0, 5'd7, 1'b0);
        tick();
        checkOutput();

        // 4. Stall with a WB write to rs1 that must be kept after WB leaves.
        applyStimulus(1'b1, 3'd3, 5'd1, 5'd2, 32'd1, 32'd2, 32'h0, 1'b0, 5'd9, 1'b1);
        ex_ready = 1'b0;
        expectOut("or_captured", 1'b1, 1'b0, EN_OR, 32'd1, 32'd2, 5'd9, 1'b1);
        tick();
        checkOutput();
        id_valid = 1'b0;
        setWb(1'b1, 5'd1, 32'd9);
        expectOut("stall_wb_fwd", 1'b1, 1'b0, EN_OR, 32'd9, 32'd2, 5'd9, 1'b1);
        #1;
        checkOutput();
        tick();
        setWb(1'b0, 5'd0, 32'h0);
        expectOut("stall_refresh", 1'b1, 1'b0, EN_OR, 32'd9, 32'd2, 5'd9, 1'b1);
        #1;
        checkOutput();
        expectOut("stall_hold", 1'b1, 1'b0, EN_OR, 32'd9, 32'd2, 5'd9, 1'b1);
        tick();
        checkOutput();
        ex_ready = 1'b1;
        expectOut("drain_or", 1'b0, 1'b1, EN_NONE, 32'h0, 32'h0, 5'd9, 1'b0);
        tick();
        checkOutput();

        // rs2 match with a pending load is ignored when the immediate is used.
        applyStimulus(1'b1, 3'd2, 5'd5, 5'd4, 32'h50, 32'd3, 32'h123, 1'b1, 5'd10, 1'b1);
        setMem(1'b1, 5'd4, 32'h77, 1'b0);
        expectOut("imm_no_hazard", 1'b1, 1'b1, EN_XOR, 32'h50, 32'h123, 5'd10, 1'b1);
        tick();
        checkOutput();

        // 5. Flush drops both the held and the offered instruction.
        setMem(1'b0, 5'd0, 32'h0, 1'b0);
        ex_ready = 1'b0;
        flush    = 1'b1;
        applyStimulus(1'b1, 3'd0, 5'd1, 5'd2, 32'hAA, 32'hBB, 32'h0, 1'b0, 5'd11, 1'b1);
        expectOut("flush_ready", 1'b1, 1'b1, EN_XOR, 32'h50, 32'h123, 5'd10, 1'b1);
        #1;
        checkOutput();
        expectOut("flush_empty", 1'b0, 1'b1, EN_NONE, 32'h0, 32'h0, 5'd10, 1'b0);
        tick();
        checkOutput();
        flush    = 1'b0;
        id_valid = 1'b0;
        expectOut("flush_dropped", 1'b0, 1'b1, EN_NONE, 32'h0, 32'h0, 5'd10, 1'b0);
        tick();
        checkOutput();

        // 6. x0 is never forwarded, even when MEM "writes" x0.
        applyStimulus(1'b1, 3'd4, 5'd0, 5'd2, 32'd5, 32'h0F, 32'h0, 1'b0, 5'd0, 1'b0);
        setMem(1'b1, 5'd0, 32'hFF, 1'b1);
        expectOut("x0_and", 1'b1, 1'b0, EN_AND, 32'h0, 32'h0F, 5'd0, 1'b0);
        tick();
        checkOutput();
        setMem(1'b0, 5'd0, 32'h0, 1'b0);
        id_valid = 1'b0;
        ex_ready = 1'b1;
        expectOut("drain_and", 1'b0, 1'b1, EN_NONE, 32'h0, 32'h0, 5'd0, 1'b0);
        tick();
        checkOutput();

        // Illegal op: valid but no enable, then asynchronous reset mid-stall.
        applyStimulus(1'b1, 3'd6, 5'd1, 5'd2, 32'h11, 32'h22, 32'h0, 1'b0, 5'd3, 1'b1);
        ex_ready = 1'b0;
        expectOut("illegal_op", 1'b1, 1'b0, EN_NONE, 32'h11, 32'h22, 5'd3, 1'b1);
        tick();
        checkOutput();
        id_valid = 1'b0;
        #2;
        rst_n = 1'b0;
        expectOut("async_reset", 1'b0, 1'b1, EN_NONE, 32'h0, 32'h0, 5'd0, 1'b0);
        #1;
        checkOutput();
        @(negedge clk);
        rst_n = 1'b1;
        expectOut("post_reset", 1'b0, 1'b1, EN_NONE, 32'h0, 32'h0, 5'd0, 1'b0);
        tick();
        checkOutput();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
